// File: rtl/sobel_window_streamer_if.sv
// Pixel, accelerator and edge-stream signals of the Sobel window streamer.
// slave is the streamer's view; master is the surrounding system's view.
interface sobel_window_streamer_if;
   logic        start;
   logic [7:0]  pix_in;
   logic        pix_valid;
   logic        pix_ready;
   logic [71:0] acc_window;
   logic        acc_trigger;
   logic [31:0] acc_result;
   logic [7:0]  edge_out;
   logic        edge_valid;
   logic        edge_ready;
   logic        busy;
   logic        frame_done;

   modport slave (
      input  start, pix_in, pix_valid, acc_result, edge_ready,
      output pix_ready, acc_window, acc_trigger, edge_out, edge_valid, busy, frame_done
   );

   modport master (
      output start, pix_in, pix_valid, acc_result, edge_ready,
      input  pix_ready, acc_window, acc_trigger, edge_out, edge_valid, busy, frame_done
   );
endinterface

// File: rtl/sobel_window_streamer.sv
// Raster pixel stream to 3x3 Sobel windows with two line buffers and edge-stream output.
// Optional macro EDGE_THRESH_EN binarizes captured results against THRESH.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting pixels, triggering interior windows
// FLUSH | last pixel in, draining pending result and output
// DONE  | one-cycle frame_done pulse
module sobel_window_streamer #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int THRESH = 128
) (
   input logic                     clk,
   input logic                     rst_n,
   sobel_window_streamer_if.slave  bus
);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam logic [7:0] THR8 = 8'(THRESH);

   logic [1:0]    state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [23:0]   col0_q, col0_d, col1_q, col1_d, col2_q, col2_d;
   logic          tp_q, tp_d;
   logic [7:0]    edge_q, edge_d;
   logic          ev_q, ev_d;
   logic [7:0]    lb0_q [IMG_W];
   logic [7:0]    lb1_q [IMG_W];

   logic       accept, capture, interior, x_last, y_last, last_pix;
   logic [7:0] cap_val;
   logic       unused_ok;

   assign x_last   = (x_q == XW'(IMG_W - 1));
   assign y_last   = (y_q == YW'(IMG_H - 1));
   assign capture  = tp_q && (!ev_q || bus.edge_ready);
   assign bus.pix_ready = (state_q == S_RUN) && (!tp_q || capture);
   assign accept   = bus.pix_valid && bus.pix_ready;
   assign interior = accept && (x_q >= XW'(2)) && (y_q >= YW'(2));
   assign last_pix = accept && x_last && y_last;

`ifdef EDGE_THRESH_EN
   assign cap_val = (bus.acc_result[7:0] >= THR8) ? 8'hFF : 8'h00;
`else
   assign cap_val = bus.acc_result[7:0];
`endif
   assign unused_ok = ^{bus.acc_result[31:8], THR8};

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      col0_d  = col0_q;
      col1_d  = col1_q;
      col2_d  = col2_q;
      tp_d    = tp_q;
      edge_d  = edge_q;
      ev_d    = ev_q;

      // a new interior window in the same cycle as a capture keeps tp set
      if (capture)  tp_d = 1'b0;
      if (interior) tp_d = 1'b1;

      if (capture) begin
         ev_d   = 1'b1;
         edge_d = cap_val;
      end else if (bus.edge_ready) begin
         ev_d = 1'b0;
      end

      if (accept) begin
         col0_d = col1_q;
         col1_d = col2_q;
         col2_d = {lb1_q[x_q], lb0_q[x_q], bus.pix_in};
         if (x_last) begin
            x_d = '0;
            y_d = y_last ? '0 : y_q + YW'(1);
         end else begin
            x_d = x_q + XW'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_RUN;
               x_d     = '0;
               y_d     = '0;
            end
         end
         S_RUN:   if (last_pix) state_d = S_FLUSH;
         // look at next-state values so DONE follows the final handoff directly
         S_FLUSH: if (!tp_d && !ev_d) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         col0_q  <= '0;
         col1_q  <= '0;
         col2_q  <= '0;
         tp_q    <= 1'b0;
         edge_q  <= '0;
         ev_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         col0_q  <= col0_d;
         col1_q  <= col1_d;
         col2_q  <= col2_d;
         tp_q    <= tp_d;
         edge_q  <= edge_d;
         ev_q    <= ev_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         lb1_q[x_q] <= lb0_q[x_q];
         lb0_q[x_q] <= bus.pix_in;
      end
   end

   assign bus.acc_trigger = tp_q;
   assign bus.acc_window  = {col0_q[23:16], col1_q[23:16], col2_q[23:16],
                             col0_q[15:8],  col1_q[15:8],  col2_q[15:8],
                             col0_q[7:0],   col1_q[7:0],   col2_q[7:0]};
   assign bus.edge_out    = edge_q;
   assign bus.edge_valid  = ev_q;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.frame_done  = (state_q == S_DONE);
endmodule

// File: tb/tb_sobel_window_streamer.sv
// Scoreboard bench for sobel_window_streamer on 5x5 frames with a behavioural Sobel accelerator.
module tb_sobel_window_streamer;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sobel_window_streamer_if bus();

   sobel_window_streamer #(.IMG_W(5), .IMG_H(5), .THRESH(100)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q [$];
   int cyc = 0;
   int acc22_cyc = -10;
   int cur_kind = 0;
   int fd_count = 0;
   int last_hs_cyc = -10;
   int rdy_mode = 0;
   int stall_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // combinational accelerator: |Gx|+|Gy| clamped, junk in the unused upper bits
   function automatic logic [31:0] sobel_acc(input logic [71:0] w);
      int p [9];
      int gx, gy, s;
      for (int i = 0; i < 9; i++) p[i] = int'(w[71-8*i -: 8]);
      gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
      gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
      if (gx < 0) gx = -gx;
      if (gy < 0) gy = -gy;
      s = gx + gy;
      if (s > 255) s = 255;
      return {24'hA5C3E1, 8'(s)};
   endfunction

   assign bus.acc_result = sobel_acc(bus.acc_window);

   function automatic logic [7:0] pix_val(input int kind, input int x, input int y);
      case (kind)
         0:       return (x >= 3) ? 8'd255 : 8'd0;
         1:       return 8'd128;
         2:       return 8'(x*10 + y);
         default: return (y >= 3) ? 8'd255 : 8'd0;
      endcase
   endfunction

   // hand-computed results per output centre (ox+1, oy+1)
   function automatic logic [7:0] exp_out(input int kind, input int ox, input int oy);
      int v;
      case (kind)
         0:       v = (ox == 0) ? 0 : 255;
         1:       v = 0;
         2:       v = 88;
         default: v = (oy == 0) ? 0 : 255;
      endcase
`ifdef EDGE_THRESH_EN
      return (v >= 100) ? 8'hFF : 8'h00;
`else
      return 8'(v);
`endif
   endfunction

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_pix_ready"},   bus.pix_ready,   0);
      chk({tag, "_acc_trigger"}, bus.acc_trigger, 0);
      chk({tag, "_acc_window"},  bus.acc_window,  0);
      chk({tag, "_edge_out"},    bus.edge_out,    0);
      chk({tag, "_edge_valid"},  bus.edge_valid,  0);
      chk({tag, "_busy"},        bus.busy,        0);
      chk({tag, "_frame_done"},  bus.frame_done,  0);
   endtask

   initial begin
      bus.edge_ready = 1'b1;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0: bus.edge_ready = 1'b1;
            1: bus.edge_ready = 1'($urandom_range(0, 1));
            default: begin
               bus.edge_ready = 1'b0;
               if (stall_cnt > 0) stall_cnt--;
               else rdy_mode = 0;
            end
         endcase
      end
   end

   // monitor: sampled 3 ns before each rising edge
   initial begin
      logic [71:0] pw;
      logic [7:0]  pe;
      logic        pt, pev, prdy, pvld;
      int          srun;
      pvld = 1'b0;
      srun = 0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            pvld = 1'b0;
            srun = 0;
            continue;
         end
         if (bus.edge_valid && bus.edge_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL extra_output: got %0h expected no output (cycle %0d)", bus.edge_out, cyc);
            end else begin
               chk("edge_out", bus.edge_out, exp_q.pop_front());
            end
            last_hs_cyc = cyc;
         end
         if (bus.frame_done) begin
            fd_count++;
            chk("frame_done_timing", cyc, last_hs_cyc + 1);
         end
         if (pvld && pt && pev && !prdy) chk("window_stable", bus.acc_window, pw);
         if (bus.edge_valid && !bus.edge_ready) srun++;
         else srun = 0;
         if (srun >= 2) chk("edge_out_held", bus.edge_out, pe);
         if (srun >= 3 && bus.pix_valid) chk("pix_ready_stall", bus.pix_ready, 0);
         if (cyc == acc22_cyc + 1) begin
            chk("trigger_latency", bus.acc_trigger, 1);
            chk("edge_valid_not_early", bus.edge_valid, 0);
            if (cur_kind == 2) chk("window_at_2_2", bus.acc_window, 72'h000A14010B15020C16);
         end
         if (cyc == acc22_cyc + 2) chk("edge_valid_latency", bus.edge_valid, 1);
         pw   = bus.acc_window;
         pe   = bus.edge_out;
         pt   = bus.acc_trigger;
         pev  = bus.edge_valid;
         prdy = bus.edge_ready;
         pvld = 1'b1;
      end
   end

   task automatic feed_frame(input int kind, input int stall_at, input int reset_at);
      int t, fd0;
      cur_kind  = kind;
      acc22_cyc = -10;
      t = 0;
      while (bus.busy && t < 100) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      #2;
      chk("busy_after_start", bus.busy, 1);
      fd0 = fd_count;
      for (int oy = 0; oy < 3; oy++)
         for (int ox = 0; ox < 3; ox++)
            exp_q.push_back(exp_out(kind, ox, oy));
      for (int y = 0; y < 5; y++) begin
         for (int x = 0; x < 5; x++) begin
            @(negedge clk);
            if (y*5 + x == reset_at) begin
               bus.pix_valid = 1'b0;
               rst_n = 1'b0;
               @(negedge clk);
               #2;
               chk_reset_values("midframe_reset");
               rst_n = 1'b1;
               exp_q.delete();
               repeat (10) @(negedge clk);
               #2;
               chk("no_frame_done_after_abort", fd_count, fd0);
               chk("idle_after_abort", bus.busy, 0);
               return;
            end
            bus.pix_in    = pix_val(kind, x, y);
            bus.pix_valid = 1'b1;
            if (y*5 + x == stall_at) begin
               stall_cnt = 19;
               rdy_mode  = 2;
            end
            t = 0;
            forever begin
               #2;
               if (bus.pix_ready) break;
               t++;
               if (t > 200) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL pix_accept_timeout: got pix_ready=0 for %0d cycles expected acceptance", t);
                  bus.pix_valid = 1'b0;
                  return;
               end
               @(negedge clk);
            end
            if (x == 2 && y == 2) acc22_cyc = cyc;
         end
      end
      @(negedge clk);
      bus.pix_valid = 1'b0;
      t = 0;
      while (fd_count == fd0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      #2;
      chk("frame_done_once", fd_count, fd0 + 1);
      chk("outputs_all_consumed", exp_q.size(), 0);
      chk("busy_low_after_done", bus.busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1);
   end

   initial begin
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.pix_in    = 8'd0;
      bus.pix_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      chk_reset_values("reset");
      rst_n = 1'b1;
      @(negedge clk);
      #2;
      chk("idle_pix_ready", bus.pix_ready, 0);

      feed_frame(0, -1, -1);
      feed_frame(1, -1, -1);
      feed_frame(2, 16, -1);
      rdy_mode = 1;
      feed_frame(3, -1, -1);
      rdy_mode = 0;
      feed_frame(0, -1, 23);
      feed_frame(0, -1, -1);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sobel_window_streamer.md
# sobel_window_streamer

Front-end feeder for the combinational Sobel edge accelerator. Accepts a raster-order 8-bit grayscale pixel stream with two on-chip line buffers and assembles every interior 3x3 neighbourhood into the accelerator's 72-bit window format. It drives the accelerator trigger, captures the edge-strength result and emits a (IMG_W-2)x(IMG_H-2) edge-pixel stream with valid/ready backpressure.

## Interface
- IMG_W, 64: pixels per input row (>=3)
- IMG_H, 64: rows per input frame (>=3)
- THRESH, 128: binarization threshold (used only with EDGE_THRESH_EN)
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- pix_in  in  8  unsigned input pixel
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  streamer accepts pix_in this cycle
- acc_window  out  72  3x3 window, MSB byte = p00 (top-left), row-major, LSB byte = p22
- acc_trigger  out  1  window valid; accelerator result sampled while high
- acc_result  in  32  accelerator output; only [7:0] used
- edge_out  out  8  edge pixel
- edge_valid  out  1  edge_out valid
- edge_ready  in  1  downstream accepts edge_out
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse after final edge pixel handed off

## Operation
- States: IDLE -> RUN (start) -> FLUSH (last pixel accepted) -> DONE (1 cycle, frame_done=1) -> IDLE. start outside IDLE ignored.
- Counters x in [0,IMG_W-1], y in [0,IMG_H-1]; cleared on entry to RUN; x wraps to 0 and y increments on accept at x=IMG_W-1.
- Line buffers lb0 (row y-1), lb1 (row y-2), IMG_W x 8 each. On accept at (x,y): window columns shift left (col0<=col1, col1<=col2); new col2 = {lb1[x], lb0[x], pix_in} top to bottom; then lb1[x]<=lb0[x], lb0[x]<=pix_in.
- Window is interior when x>=2 and y>=2 at accept time; then trigger-pending flag tp sets. acc_trigger = tp. acc_window = current window register.
- Capture: occurs when tp && (!edge_valid || edge_ready); edge_out <= acc_result[7:0], edge_valid<=1, tp clears unless a new interior pixel is accepted the same cycle (then tp stays 1).
- edge_valid clears on edge_ready without concurrent capture.
- pix_ready = (state==RUN) && (!tp || capture). Window register never overwritten before its result is captured.
- Output order: raster, centre (x-1,y-1) of each interior window. Exactly (IMG_W-2)*(IMG_H-2) outputs per frame.
- FLUSH exits to DONE when tp==0 and edge_valid==0.
- Line buffer contents not reset; stale data is unreachable because rows 0-1 never trigger.

## Timing
- Reset values: pix_ready=0, acc_trigger=0, acc_window=0, edge_out=0, edge_valid=0, busy=0, frame_done=0; state IDLE, x=y=0, tp=0.
- Reset mid-frame: all state above restored next cycle; partial frame discarded, no frame_done.
- Latency without backpressure: interior pixel accepted cycle N -> acc_trigger high cycle N+1 -> edge_valid high cycle N+2.
- Throughput: 1 pixel/cycle while edge_ready=1.
- acc_trigger may stay high multiple cycles under backpressure; acc_window stable throughout.
- frame_done: cycle after the last edge_valid&&edge_ready handshake (DONE state), then IDLE; new start accepted the following cycle.
- pix_valid with pix_ready=0: no state change.

## Configuration
- EDGE_THRESH_EN defined: captured edge_out = (acc_result[7:0] >= THRESH) ? 8'hFF : 8'h00.
- Undefined: edge_out = acc_result[7:0] unmodified; THRESH unused.

## Test plan
- IMG_W=IMG_H=5, every row 0,0,0,255,255, edge_ready=1, real accelerator attached -> 9 outputs, each row 0,255,255; frame_done pulses once; first edge_valid 2 cycles after the pixel at (2,2) is accepted.
- IMG_W=IMG_H=5, all pixels 128 -> 9 outputs all 0; busy low after DONE.
- Default 64x64 random image, edge_ready toggled randomly (50%) -> exactly 3844 outputs matching software Sobel |Gx|+|Gy| clamp 255; no drop/duplicate; acc_window stable while acc_trigger high and unhandshaken.
- edge_ready held 0 for 20 cycles mid-row -> pix_ready drops within 2 cycles of first stalled output, edge_out held; resumes with no lost pixels.
- rst_n=0 for 1 cycle at (x=3,y=4) of a 5x5 frame -> all outputs at reset values next cycle, no frame_done; subsequent start + full frame produces correct 9 outputs.
- EDGE_THRESH_EN, THRESH=100, vertical-edge 5x5 frame -> outputs 0x00,0xFF,0xFF per row.
